// File: rtl/prim_sync_debounce_pkg.sv
// prim_sync_debounce_pkg: shared FSM state type and counter sizing helper.
package prim_sync_debounce_pkg;

   typedef enum logic {StStable, StFilter} debounce_st_e;

   function automatic int cnt_width(int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/prim_sync_debounce_if.sv
// prim_sync_debounce_if: debounce data bundle; clr_i/event_o exist only with PRIM_SYNC_DEBOUNCE_STICKY_EN.
interface prim_sync_debounce_if
   import prim_sync_debounce_pkg::*;
#(
   parameter int Width = 16
);
   logic [Width-1:0] d_i;
   logic [Width-1:0] q_o;
   logic [Width-1:0] rise_o;
   logic [Width-1:0] fall_o;
`ifdef PRIM_SYNC_DEBOUNCE_STICKY_EN
   logic [Width-1:0] clr_i;
   logic [Width-1:0] event_o;
   modport master (output d_i, clr_i, input q_o, rise_o, fall_o, event_o);
   modport slave (input d_i, clr_i, output q_o, rise_o, fall_o, event_o);
`else
   modport master (output d_i, input q_o, rise_o, fall_o);
   modport slave (input d_i, output q_o, rise_o, fall_o);
`endif
endinterface

// File: rtl/prim_sync_debounce_bit.sv
// prim_sync_debounce_bit: single-bit debounce FSM with registered level and edge pulses.
module prim_sync_debounce_bit
   import prim_sync_debounce_pkg::*;
#(
   parameter int   DebounceCycles = 4,
   parameter logic ResetValue     = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int CntW = cnt_width(DebounceCycles);

   debounce_st_e    st_q, st_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] cnt_inc;
   logic            q_d, rise_d, fall_d;
   logic            diff, commit;

   assign diff    = d_i != q_o;
   assign cnt_inc = cnt_q + CntW'(1);
   // A single-cycle filter commits straight from STABLE, so FILTER is never entered.
   assign commit  = diff && ((st_q == StStable) ? (DebounceCycles == 1)
                                               : (cnt_inc == CntW'(DebounceCycles)));

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      q_d    = q_o;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (commit) begin
         st_d   = StStable;
         cnt_d  = '0;
         q_d    = d_i;
         rise_d = d_i;
         fall_d = ~d_i;
      end else if (st_q == StStable) begin
         st_d  = diff ? StFilter : StStable;
         cnt_d = diff ? CntW'(1) : '0;
      end else begin
         st_d  = diff ? StFilter : StStable;
         cnt_d = diff ? cnt_inc : '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         st_q   <= StStable;
         cnt_q  <= '0;
         q_o    <= ResetValue;
         rise_o <= 1'b0;
         fall_o <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         q_o    <= q_d;
         rise_o <= rise_d;
         fall_o <= fall_d;
      end
   end

endmodule

// File: rtl/prim_sync_debounce.sv
// prim_sync_debounce: per-bit debounce filter and edge detector for pre-synchronized inputs.
// Optional sticky edge record enabled by PRIM_SYNC_DEBOUNCE_STICKY_EN.
module prim_sync_debounce
   import prim_sync_debounce_pkg::*;
#(
   parameter int               Width          = 16,
   parameter int               DebounceCycles = 4,
   parameter logic [Width-1:0] ResetValue     = '0
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   prim_sync_debounce_if.slave  bus
);
   logic [Width-1:0] q, rise, fall;

   for (genvar i = 0; i < Width; i++) begin : g_bit
      prim_sync_debounce_bit #(
         .DebounceCycles (DebounceCycles),
         .ResetValue     (ResetValue[i])
      ) u_bit (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .d_i    (bus.d_i[i]),
         .q_o    (q[i]),
         .rise_o (rise[i]),
         .fall_o (fall[i])
      );
   end

   assign bus.q_o    = q;
   assign bus.rise_o = rise;
   assign bus.fall_o = fall;

`ifdef PRIM_SYNC_DEBOUNCE_STICKY_EN
   logic [Width-1:0] event_q;

   // Set takes priority over a simultaneous clear.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) event_q <= '0;
      else         event_q <= (event_q & ~bus.clr_i) | rise | fall;
   end

   assign bus.event_o = event_q;
`endif

endmodule

// File: tb/tb_prim_sync_debounce.sv
// tb_prim_sync_debounce: directed checks for DebounceCycles=4 and DebounceCycles=1 instances.
module tb_prim_sync_debounce;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   prim_sync_debounce_if #(.Width(4)) bus0 ();
   prim_sync_debounce_if #(.Width(4)) bus1 ();

   prim_sync_debounce #(.Width(4), .DebounceCycles(4), .ResetValue(4'h0)) dut0 (
      .clk_i (clk), .rst_ni (rst_n), .bus (bus0.slave));
   prim_sync_debounce #(.Width(4), .DebounceCycles(1), .ResetValue(4'h0)) dut1 (
      .clk_i (clk), .rst_ni (rst_n), .bus (bus1.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus0.d_i = 4'hF;
      bus1.d_i = 4'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (bus0.q_o !== 4'h0 || bus0.rise_o !== 4'h0 || bus0.fall_o !== 4'h0) begin
            fails++;
            $display("FAIL reset_hold: q=%h rise=%h fall=%h expected all 0", bus0.q_o, bus0.rise_o, bus0.fall_o);
         end
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         tests++;
         if (bus0.q_o !== ((i >= 4) ? 4'hF : 4'h0) || bus0.rise_o !== ((i == 4) ? 4'hF : 4'h0)) begin
            fails++;
            $display("FAIL reset_release[%0d]: q=%h rise=%h expected q=%h rise=%h", i, bus0.q_o,
                     bus0.rise_o, (i >= 4) ? 4'hF : 4'h0, (i == 4) ? 4'hF : 4'h0);
         end
      end
   endtask

   task automatic test_glitch();
      bus0.d_i = 4'h0;
      for (int i = 0; i < 6; i++) tick();
      bus0.d_i = 4'h1;
      for (int i = 1; i <= 8; i++) begin
         if (i == 4) bus0.d_i = 4'h0;
         tick();
         tests++;
         if (bus0.q_o[0] !== 1'b0 || bus0.rise_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL glitch[%0d]: q0=%b rise0=%b expected 0 0", i, bus0.q_o[0], bus0.rise_o[0]);
         end
      end
   endtask

   task automatic test_clean_edge();
      bus0.d_i = 4'h2;
      for (int i = 1; i <= 10; i++) begin
         tick();
         tests++;
         if (bus0.q_o[1] !== (i >= 4) || bus0.rise_o[1] !== (i == 4) || bus0.fall_o[1] !== 1'b0) begin
            fails++;
            $display("FAIL clean_rise[%0d]: q1=%b rise1=%b fall1=%b expected %b %b 0", i, bus0.q_o[1],
                     bus0.rise_o[1], bus0.fall_o[1], i >= 4, i == 4);
         end
      end
      bus0.d_i = 4'h0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         tests++;
         if (bus0.q_o[1] !== (i < 4) || bus0.fall_o[1] !== (i == 4) || bus0.rise_o[1] !== 1'b0) begin
            fails++;
            $display("FAIL clean_fall[%0d]: q1=%b fall1=%b rise1=%b expected %b %b 0", i, bus0.q_o[1],
                     bus0.fall_o[1], bus0.rise_o[1], i < 4, i == 4);
         end
      end
   endtask

   task automatic test_independence();
      for (int i = 1; i <= 10; i++) begin
         bus0.d_i = {1'b1, (((i - 1) / 2) % 2) == 0, 2'b00};
         tick();
         tests++;
         if (bus0.q_o[2] !== 1'b0 || bus0.rise_o[2] !== 1'b0 ||
             bus0.q_o[3] !== (i >= 4) || bus0.rise_o[3] !== (i == 4)) begin
            fails++;
            $display("FAIL independence[%0d]: q=%h rise=%h expected q3=%b rise3=%b q2=0 rise2=0", i,
                     bus0.q_o, bus0.rise_o, i >= 4, i == 4);
         end
      end
      bus0.d_i = 4'h0;
      for (int i = 0; i < 6; i++) tick();
   endtask

   task automatic test_dc1();
      logic [3:0] d, prev_q;
      prev_q = 4'h0;
      for (int i = 0; i < 20; i++) begin
         d = 4'($urandom_range(0, 15));
         bus1.d_i = d;
         tick();
         tests++;
         if (bus1.q_o !== d || bus1.rise_o !== (d & ~prev_q) || bus1.fall_o !== (~d & prev_q)) begin
            fails++;
            $display("FAIL dc1[%0d]: q=%h rise=%h fall=%h expected %h %h %h", i, bus1.q_o, bus1.rise_o,
                     bus1.fall_o, d, d & ~prev_q, ~d & prev_q);
         end
         prev_q = d;
      end
      bus1.d_i = 4'h0;
   endtask

   task automatic test_reset_mid_filter();
      bus0.d_i = 4'hF;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      tests++;
      if (bus0.q_o !== 4'h0 || bus0.rise_o !== 4'h0) begin
         fails++;
         $display("FAIL mid_reset: q=%h rise=%h expected 0 0", bus0.q_o, bus0.rise_o);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         tests++;
         if (bus0.q_o !== ((i >= 4) ? 4'hF : 4'h0) || bus0.rise_o !== ((i == 4) ? 4'hF : 4'h0)) begin
            fails++;
            $display("FAIL mid_reset_refilter[%0d]: q=%h rise=%h expected q=%h rise=%h", i, bus0.q_o,
                     bus0.rise_o, (i >= 4) ? 4'hF : 4'h0, (i == 4) ? 4'hF : 4'h0);
         end
      end
   endtask

`ifdef PRIM_SYNC_DEBOUNCE_STICKY_EN
   task automatic test_sticky();
      bus0.clr_i = 4'hF;
      tick();
      bus0.clr_i = 4'h0;
      tests++;
      if (bus0.event_o !== 4'h0) begin
         fails++;
         $display("FAIL sticky_clear_all: event=%h expected 0", bus0.event_o);
      end
      bus0.d_i = 4'hE;
      for (int i = 0; i < 4; i++) tick();
      tick();
      tests++;
      if (bus0.event_o[0] !== 1'b1) begin
         fails++;
         $display("FAIL sticky_set: event0=%b expected 1", bus0.event_o[0]);
      end
      bus0.d_i = 4'hF;
      for (int i = 0; i < 4; i++) tick();
      bus0.clr_i = 4'h1;
      tick();
      bus0.clr_i = 4'h0;
      tests++;
      if (bus0.event_o[0] !== 1'b1) begin
         fails++;
         $display("FAIL sticky_set_wins: event0=%b expected 1", bus0.event_o[0]);
      end
      bus0.clr_i = 4'h1;
      tick();
      bus0.clr_i = 4'h0;
      tests++;
      if (bus0.event_o[0] !== 1'b0) begin
         fails++;
         $display("FAIL sticky_clr: event0=%b expected 0", bus0.event_o[0]);
      end
   endtask
`endif

   initial begin
`ifdef PRIM_SYNC_DEBOUNCE_STICKY_EN
      bus0.clr_i = 4'h0;
      bus1.clr_i = 4'h0;
`endif
      test_reset();
      test_glitch();
      test_clean_edge();
      test_independence();
      test_dc1();
      test_reset_mid_filter();
`ifdef PRIM_SYNC_DEBOUNCE_STICKY_EN
      tick();
      test_sticky();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
